// File: rtl/ps_fetch_seq.sv
`default_nettype none
// ============================================================================
// Module   : ps_fetch_seq
// Purpose  : Program sequencer / fetch stage ahead of the PM read port. Owns
//            the PC, issues PM reads, pairs the returned instruction with its
//            fetch address and valid bit, and handles jump, call and return
//            through a small hardware return stack.
// Ports    : clk_fetch/reset      - fetch clock, async active-low reset
//            ps_stall             - decode back-pressure (hold everything)
//            dcd_jmp/call/rts     - redirect requests from decode
//            dcd_jmp_add          - jump/call target
//            pm_ps_op             - registered PM read data
//            ps_pm_cslt/wrb/add   - PM read port controls and address
//            ps_dcd_inst/vld/pc   - instruction, valid and address to decode
//            ps_stk_ovf/udf       - sticky return-stack overflow/underflow
// Revision : 1.0 - initial release
// ============================================================================
module ps_fetch_seq #(
    parameter int PMA_SIZE  = 16,
    parameter int PMD_SIZE  = 32,
    parameter int STK_DEPTH = 4
) (
    input  logic                clk_fetch,
    input  logic                reset,
    input  logic                ps_stall,
    input  logic                dcd_jmp,
    input  logic                dcd_call,
    input  logic                dcd_rts,
    input  logic [PMA_SIZE-1:0] dcd_jmp_add,
    input  logic [PMD_SIZE-1:0] pm_ps_op,
    output logic                ps_pm_cslt,
    output logic                ps_pm_wrb,
    output logic [PMA_SIZE-1:0] ps_pm_add,
    output logic [PMD_SIZE-1:0] ps_dcd_inst,
    output logic                ps_dcd_vld,
    output logic [PMA_SIZE-1:0] ps_dcd_pc,
    output logic                ps_stk_ovf,
    output logic                ps_stk_udf
);

    // Stack pointer counts 0..STK_DEPTH, so it needs one bit above the index.
    localparam int SP_W = $clog2(STK_DEPTH) + 1;
    localparam logic [SP_W-1:0]     c_SP_FULL = SP_W'(STK_DEPTH);
    localparam logic [SP_W-1:0]     c_SP_ONE  = SP_W'(1);
    localparam logic [PMA_SIZE-1:0] c_PC_ONE  = PMA_SIZE'(1);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [PMA_SIZE-1:0] r_pc;
    logic [PMA_SIZE-1:0] w_pc_nxt;
    logic [PMA_SIZE-1:0] r_dcd_pc;
    logic                r_dcd_vld;
    logic [SP_W-1:0]     r_sp;
    logic [PMA_SIZE-1:0] r_stk [STK_DEPTH];
    logic                r_ovf;
    logic                r_udf;

    logic                w_accept;
    logic                w_redir_en;
    logic                w_do_rts;
    logic                w_do_call;
    logic                w_do_jmp;
    logic                w_redir;
    logic                w_stk_full;
    logic                w_stk_empty;
    logic [SP_W-1:0]     w_sp_m1;
    logic [PMA_SIZE-1:0] w_ret_add;

    assign w_accept    = ~ps_stall & (r_state != S_BOOT);
    // Redirects only come from a live instruction sitting in decode.
    assign w_redir_en  = w_accept & r_dcd_vld;
    assign w_do_rts    = w_redir_en & dcd_rts;
    assign w_do_call   = w_redir_en & ~dcd_rts & dcd_call;
    assign w_do_jmp    = w_redir_en & ~dcd_rts & ~dcd_call & dcd_jmp;
    assign w_redir     = w_do_rts | w_do_call | w_do_jmp;
    assign w_stk_full  = (r_sp == c_SP_FULL);
    assign w_stk_empty = (r_sp == '0);
    assign w_sp_m1     = r_sp - c_SP_ONE;
    assign w_ret_add   = r_dcd_pc + c_PC_ONE;

    // Next-state / next-PC logic
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        case (r_state)
            S_BOOT: begin
                w_state_nxt = S_RUN;
            end
            S_RUN, S_FLUSH: begin
                if (w_accept) begin
                    w_state_nxt = w_redir ? S_FLUSH : S_RUN;
                    if (w_do_rts) begin
                        w_pc_nxt = w_stk_empty ? '0 : r_stk[w_sp_m1[SP_W-2:0]];
                    end else if (w_do_call || w_do_jmp) begin
                        w_pc_nxt = dcd_jmp_add;
                    end else begin
                        w_pc_nxt = r_pc + c_PC_ONE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk_fetch or negedge reset) begin
        if (!reset) begin
            r_state <= S_BOOT;
            r_pc    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

    // Decode-side tag: the fetch issued on a redirect edge is the squashed one.
    always_ff @(posedge clk_fetch or negedge reset) begin
        if (!reset) begin
            r_dcd_pc  <= '0;
            r_dcd_vld <= 1'b0;
        end else if (w_accept) begin
            r_dcd_pc  <= r_pc;
            r_dcd_vld <= ~w_redir;
        end
    end

    // Return-stack pointer and sticky error flags
    always_ff @(posedge clk_fetch or negedge reset) begin
        if (!reset) begin
            r_sp  <= '0;
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            if (w_do_call) begin
                if (w_stk_full) begin
                    r_ovf <= 1'b1;
                end else begin
                    r_sp <= r_sp + c_SP_ONE;
                end
            end else if (w_do_rts) begin
                if (w_stk_empty) begin
                    r_udf <= 1'b1;
                end else begin
                    r_sp <= w_sp_m1;
                end
            end
        end
    end

    // Stack storage carries no reset; contents are meaningless until pushed.
    always_ff @(posedge clk_fetch) begin
        if (w_do_call && !w_stk_full) begin
            r_stk[r_sp[SP_W-2:0]] <= w_ret_add;
        end
    end

    assign ps_pm_cslt  = (r_state != S_BOOT) & ~ps_stall;
    assign ps_pm_wrb   = 1'b0;
    assign ps_pm_add   = r_pc;
    assign ps_dcd_inst = pm_ps_op;
    assign ps_dcd_vld  = r_dcd_vld;
    assign ps_dcd_pc   = r_dcd_pc;
    assign ps_stk_ovf  = r_ovf;
    assign ps_stk_udf  = r_udf;

endmodule
`default_nettype wire

// File: tb/tb_ps_fetch_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps_fetch_seq
// Purpose  : Directed self-checking bench for ps_fetch_seq. A PM model holding
//            PM[i]=i answers reads one cycle after the address is presented.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps_fetch_seq;

    logic        clk_fetch = 1'b0;
    logic        reset = 1'b0;
    logic        ps_stall = 1'b0;
    logic        dcd_jmp = 1'b0;
    logic        dcd_call = 1'b0;
    logic        dcd_rts = 1'b0;
    logic [15:0] dcd_jmp_add = 16'h0;
    logic [31:0] pm_ps_op = 32'h0;
    logic        ps_pm_cslt;
    logic        ps_pm_wrb;
    logic [15:0] ps_pm_add;
    logic [31:0] ps_dcd_inst;
    logic        ps_dcd_vld;
    logic [15:0] ps_dcd_pc;
    logic        ps_stk_ovf;
    logic        ps_stk_udf;

    int total = 0;
    int bad   = 0;

    ps_fetch_seq #(.PMA_SIZE(16), .PMD_SIZE(32), .STK_DEPTH(4)) dut (
        .clk_fetch   (clk_fetch),
        .reset       (reset),
        .ps_stall    (ps_stall),
        .dcd_jmp     (dcd_jmp),
        .dcd_call    (dcd_call),
        .dcd_rts     (dcd_rts),
        .dcd_jmp_add (dcd_jmp_add),
        .pm_ps_op    (pm_ps_op),
        .ps_pm_cslt  (ps_pm_cslt),
        .ps_pm_wrb   (ps_pm_wrb),
        .ps_pm_add   (ps_pm_add),
        .ps_dcd_inst (ps_dcd_inst),
        .ps_dcd_vld  (ps_dcd_vld),
        .ps_dcd_pc   (ps_dcd_pc),
        .ps_stk_ovf  (ps_stk_ovf),
        .ps_stk_udf  (ps_stk_udf)
    );

    always #5 clk_fetch = ~clk_fetch;

    // PM model: registered read, contents PM[i] = i
    always @(posedge clk_fetch) begin
        if (ps_pm_cslt) pm_ps_op <= {16'h0000, ps_pm_add};
    end

    task automatic step();
        @(posedge clk_fetch);
        #1;
    endtask

    // Advance until address a is valid in decode (bounded); checks its data too.
    task automatic wait_for(input logic [15:0] a);
        int n = 0;
        while (!(ps_dcd_vld === 1'b1 && ps_dcd_pc === a) && n < 300) begin
            step();
            n++;
        end
        total++;
        if (!(ps_dcd_vld === 1'b1 && ps_dcd_pc === a)) begin
            bad++;
            $display("FAIL wait_for: dcd_pc=%h vld=%b, want pc=%h vld=1", ps_dcd_pc, ps_dcd_vld, a);
        end
        total++;
        if (ps_dcd_inst !== {16'h0000, a}) begin bad++; $display("FAIL wait_inst: got %h want %h", ps_dcd_inst, {16'h0000, a}); end
    endtask

    task automatic test_reset();
        step();
        step();
        total++; if (ps_pm_cslt !== 1'b0) begin bad++; $display("FAIL rst_cslt: got %b want 0", ps_pm_cslt); end
        total++; if (ps_pm_wrb !== 1'b0) begin bad++; $display("FAIL rst_wrb: got %b want 0", ps_pm_wrb); end
        total++; if (ps_dcd_vld !== 1'b0) begin bad++; $display("FAIL rst_vld: got %b want 0", ps_dcd_vld); end
        total++; if (ps_dcd_pc !== 16'h0) begin bad++; $display("FAIL rst_dpc: got %h want 0000", ps_dcd_pc); end
        total++; if ({ps_stk_ovf, ps_stk_udf} !== 2'b00) begin bad++; $display("FAIL rst_flags: got %b want 00", {ps_stk_ovf, ps_stk_udf}); end
        reset = 1'b1;
        // cycle 0: BOOT
        total++; if (ps_pm_cslt !== 1'b0) begin bad++; $display("FAIL boot_cslt: got %b want 0", ps_pm_cslt); end
        total++; if (ps_pm_add !== 16'h0) begin bad++; $display("FAIL boot_add: got %h want 0000", ps_pm_add); end
        step();
        // cycle 1: first RUN fetch of address 0
        total++; if (ps_pm_cslt !== 1'b1) begin bad++; $display("FAIL run1_cslt: got %b want 1", ps_pm_cslt); end
        total++; if (ps_pm_add !== 16'h0) begin bad++; $display("FAIL run1_add: got %h want 0000", ps_pm_add); end
        total++; if (ps_dcd_vld !== 1'b0) begin bad++; $display("FAIL run1_vld: got %b want 0", ps_dcd_vld); end
        for (int k = 0; k < 4; k++) begin
            step();
            total++; if (ps_pm_add !== 16'(k + 1)) begin bad++; $display("FAIL seq_add: got %h want %h", ps_pm_add, 16'(k + 1)); end
            total++; if (ps_dcd_vld !== 1'b1) begin bad++; $display("FAIL seq_vld: got %b want 1", ps_dcd_vld); end
            total++; if (ps_dcd_pc !== 16'(k)) begin bad++; $display("FAIL seq_dpc: got %h want %h", ps_dcd_pc, 16'(k)); end
            total++; if (ps_dcd_inst !== 32'(k)) begin bad++; $display("FAIL seq_inst: got %h want %h", ps_dcd_inst, 32'(k)); end
        end
    endtask

    task automatic test_jump();
        wait_for(16'h0005);
        dcd_jmp = 1'b1; dcd_jmp_add = 16'h0040;
        step();
        dcd_jmp = 1'b0;
        total++; if (ps_pm_add !== 16'h0040) begin bad++; $display("FAIL jmp_add: got %h want 0040", ps_pm_add); end
        total++; if (ps_dcd_vld !== 1'b0) begin bad++; $display("FAIL jmp_squash: got vld=%b want 0", ps_dcd_vld); end
        step();
        total++; if (ps_dcd_pc !== 16'h0040) begin bad++; $display("FAIL jmp_dpc: got %h want 0040", ps_dcd_pc); end
        total++; if (ps_dcd_vld !== 1'b1) begin bad++; $display("FAIL jmp_vld: got %b want 1", ps_dcd_vld); end
        total++; if (ps_dcd_inst !== 32'h40) begin bad++; $display("FAIL jmp_inst: got %h want 00000040", ps_dcd_inst); end
    endtask

    task automatic test_nested_call();
        dcd_jmp = 1'b1; dcd_jmp_add = 16'h000E;
        step();
        dcd_jmp = 1'b0;
        wait_for(16'h0010);
        dcd_call = 1'b1; dcd_jmp_add = 16'h0100;
        step();
        dcd_call = 1'b0;
        total++; if (ps_pm_add !== 16'h0100) begin bad++; $display("FAIL call1_add: got %h want 0100", ps_pm_add); end
        wait_for(16'h0102);
        dcd_call = 1'b1; dcd_jmp_add = 16'h0200;
        step();
        dcd_call = 1'b0;
        total++; if (ps_pm_add !== 16'h0200) begin bad++; $display("FAIL call2_add: got %h want 0200", ps_pm_add); end
        wait_for(16'h0201);
        dcd_rts = 1'b1;
        step();
        dcd_rts = 1'b0;
        total++; if (ps_pm_add !== 16'h0103) begin bad++; $display("FAIL rts1_add: got %h want 0103", ps_pm_add); end
        total++; if (ps_dcd_vld !== 1'b0) begin bad++; $display("FAIL rts1_squash: got vld=%b want 0", ps_dcd_vld); end
        wait_for(16'h0103);
        // rts and call together: rts wins, call is not performed
        dcd_rts = 1'b1; dcd_call = 1'b1; dcd_jmp_add = 16'h0500;
        step();
        dcd_rts = 1'b0; dcd_call = 1'b0;
        total++; if (ps_pm_add !== 16'h0011) begin bad++; $display("FAIL rts2_add: got %h want 0011", ps_pm_add); end
        wait_for(16'h0011);
        total++; if ({ps_stk_ovf, ps_stk_udf} !== 2'b00) begin bad++; $display("FAIL nest_flags: got %b want 00", {ps_stk_ovf, ps_stk_udf}); end
    endtask

    task automatic test_ovf_udf();
        logic [15:0] ret [4];
        logic [15:0] tgt;
        logic [15:0] exp_pc;
        wait_for(16'h0013);
        ret[0] = 16'h0014;
        for (int k = 0; k < 5; k++) begin
            tgt = 16'h0300 + 16'(k * 32);
            if (k > 0 && k < 4) ret[k] = 16'h0300 + 16'((k - 1) * 32) + 16'h1;
            dcd_call = 1'b1; dcd_jmp_add = tgt;
            step();
            dcd_call = 1'b0;
            total++; if (ps_pm_add !== tgt) begin bad++; $display("FAIL ovf_call_add: got %h want %h", ps_pm_add, tgt); end
            total++; if (ps_stk_ovf !== (k == 4)) begin bad++; $display("FAIL ovf_flag: call %0d got %b want %b", k, ps_stk_ovf, k == 4); end
            wait_for(tgt);
        end
        for (int j = 0; j < 5; j++) begin
            exp_pc = (j < 4) ? ret[3 - j] : 16'h0000;
            dcd_rts = 1'b1;
            step();
            dcd_rts = 1'b0;
            total++; if (ps_pm_add !== exp_pc) begin bad++; $display("FAIL udf_rts_add: rts %0d got %h want %h", j, ps_pm_add, exp_pc); end
            total++; if (ps_stk_udf !== (j == 4)) begin bad++; $display("FAIL udf_flag: rts %0d got %b want %b", j, ps_stk_udf, j == 4); end
            total++; if (ps_stk_ovf !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b want 1", ps_stk_ovf); end
            wait_for(exp_pc);
        end
    endtask

    task automatic test_stall();
        wait_for(16'h0007);
        ps_stall = 1'b1; dcd_jmp = 1'b1; dcd_jmp_add = 16'h0080;
        #1;
        total++; if (ps_pm_cslt !== 1'b0) begin bad++; $display("FAIL stall_cslt0: got %b want 0", ps_pm_cslt); end
        for (int k = 0; k < 3; k++) begin
            step();
            total++; if (ps_pm_cslt !== 1'b0) begin bad++; $display("FAIL stall_cslt: got %b want 0", ps_pm_cslt); end
            total++; if (ps_pm_add !== 16'h0008) begin bad++; $display("FAIL stall_add: got %h want 0008", ps_pm_add); end
            total++; if (ps_dcd_inst !== 32'h7) begin bad++; $display("FAIL stall_inst: got %h want 00000007", ps_dcd_inst); end
            total++; if ({ps_dcd_vld, ps_dcd_pc} !== {1'b1, 16'h0007}) begin bad++; $display("FAIL stall_dcd: got vld=%b pc=%h want 1/0007", ps_dcd_vld, ps_dcd_pc); end
        end
        ps_stall = 1'b0;
        #1;
        total++; if (ps_pm_cslt !== 1'b1) begin bad++; $display("FAIL unstall_cslt: got %b want 1", ps_pm_cslt); end
        step();
        dcd_jmp = 1'b0;
        total++; if (ps_pm_add !== 16'h0080) begin bad++; $display("FAIL stall_jmp_add: got %h want 0080", ps_pm_add); end
        total++; if (ps_dcd_vld !== 1'b0) begin bad++; $display("FAIL stall_jmp_squash: got %b want 0", ps_dcd_vld); end
        wait_for(16'h0080);
    endtask

    task automatic test_wrap();
        dcd_jmp = 1'b1; dcd_jmp_add = 16'hFFFE;
        step();
        dcd_jmp = 1'b0;
        wait_for(16'hFFFE);
        total++; if (ps_pm_add !== 16'hFFFF) begin bad++; $display("FAIL wrap_add1: got %h want ffff", ps_pm_add); end
        step();
        total++; if (ps_pm_add !== 16'h0000) begin bad++; $display("FAIL wrap_add0: got %h want 0000", ps_pm_add); end
        total++; if (ps_dcd_pc !== 16'hFFFF) begin bad++; $display("FAIL wrap_dpc: got %h want ffff", ps_dcd_pc); end
        step();
        total++; if ({ps_dcd_vld, ps_dcd_pc, ps_dcd_inst} !== {1'b1, 16'h0000, 32'h0}) begin bad++; $display("FAIL wrap_dcd: got vld=%b pc=%h inst=%h want 1/0000/0", ps_dcd_vld, ps_dcd_pc, ps_dcd_inst); end
        total++; if (ps_pm_add !== 16'h0001) begin bad++; $display("FAIL wrap_next: got %h want 0001", ps_pm_add); end
    endtask

    task automatic test_async_reset();
        dcd_jmp = 1'b1; dcd_jmp_add = 16'h0123;
        step();
        dcd_jmp = 1'b0;
        total++; if ({ps_pm_add, ps_dcd_vld} !== {16'h0123, 1'b0}) begin bad++; $display("FAIL flush_pre: got add=%h vld=%b want 0123/0", ps_pm_add, ps_dcd_vld); end
        #2 reset = 1'b0;
        #1;
        total++; if (ps_pm_add !== 16'h0) begin bad++; $display("FAIL arst_add: got %h want 0000", ps_pm_add); end
        total++; if (ps_pm_cslt !== 1'b0) begin bad++; $display("FAIL arst_cslt: got %b want 0", ps_pm_cslt); end
        total++; if ({ps_dcd_vld, ps_dcd_pc} !== 17'h0) begin bad++; $display("FAIL arst_dcd: got vld=%b pc=%h want 0/0000", ps_dcd_vld, ps_dcd_pc); end
        total++; if ({ps_stk_ovf, ps_stk_udf} !== 2'b00) begin bad++; $display("FAIL arst_flags: got %b want 00", {ps_stk_ovf, ps_stk_udf}); end
        step();
        reset = 1'b1;
        total++; if (ps_pm_cslt !== 1'b0) begin bad++; $display("FAIL arst_boot: got %b want 0", ps_pm_cslt); end
        step();
        total++; if ({ps_pm_cslt, ps_pm_add} !== {1'b1, 16'h0}) begin bad++; $display("FAIL arst_run: got cslt=%b add=%h want 1/0000", ps_pm_cslt, ps_pm_add); end
        step();
        total++; if ({ps_dcd_vld, ps_dcd_pc} !== {1'b1, 16'h0}) begin bad++; $display("FAIL arst_first: got vld=%b pc=%h want 1/0000", ps_dcd_vld, ps_dcd_pc); end
    endtask

    initial begin
        test_reset();
        test_jump();
        test_nested_call();
        test_ovf_udf();
        test_stall();
        test_wrap();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
